// File: rtl/key_expansion_192_pkg.sv
// ---------------------------------------------------------------------------
// aes192_pkg
// Shared definitions for the AES-192 key schedule:
//   - schedule dimensions (NK, NR, NUM_WORDS, NUM_RK)
//   - 32-bit word type and the controller state encoding
//   - Rcon table and the byte S-box (sbox function)
// ---------------------------------------------------------------------------
package aes192_pkg;

    localparam int NK        = 6;
    localparam int NR        = 12;
    localparam int NUM_WORDS = 52;
    localparam int NUM_RK    = 13;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GEN  = 2'd2
    } state_e;

    // Rcon[1..8]; entry 0 here is Rcon[1].
    localparam logic [7:0] RCON [8] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

endpackage

// File: rtl/key_expansion_192_if.sv
// ---------------------------------------------------------------------------
// key_expansion_192_if
// Request/round-key bus of the AES-192 key schedule.
//   START       request, single cycle
//   CIPHER_KEY  [0:191] key, bit 0 is the MSB, word j at bits [32j:32j+31]
//   BUSY        expansion in progress
//   RK_VALID    one-cycle round-key strobe
//   RK_INDEX    [0:3] round key number 0..12
//   ROUND_KEY   [0:127] w[4k]..w[4k+3], w[4k] in bits [0:31]
//   DONE        one-cycle pulse with the last round key
// master: the requester (drives START/CIPHER_KEY); slave: the key schedule.
// ---------------------------------------------------------------------------
interface key_expansion_192_if;

    logic         START;
    logic [0:191] CIPHER_KEY;
    logic         BUSY;
    logic         RK_VALID;
    logic [0:3]   RK_INDEX;
    logic [0:127] ROUND_KEY;
    logic         DONE;

    modport master (
        output START, CIPHER_KEY,
        input  BUSY, RK_VALID, RK_INDEX, ROUND_KEY, DONE
    );

    modport slave (
        input  START, CIPHER_KEY,
        output BUSY, RK_VALID, RK_INDEX, ROUND_KEY, DONE
    );

endinterface

// File: rtl/sub_word_32.sv
// ---------------------------------------------------------------------------
// sub_word_32
// Combinational SubWord: the byte S-box applied to each of four bytes.
//   word_in   32-bit word (already rotated by the caller)
//   word_out  S-box substituted word
// ---------------------------------------------------------------------------
module sub_word_32
    import aes192_pkg::*;
(
    input  word_t word_in,
    output word_t word_out
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_out[8*b +: 8] = sbox(word_in[8*b +: 8]);
    end

endmodule

// File: rtl/key_expansion_192.sv
// ---------------------------------------------------------------------------
// key_expansion_192
// Iterative AES-192 key schedule. On an accepted START the 192-bit key is
// loaded, RK0 is emitted in the following cycle, and then one word w[i]
// (i = 6..51) is generated per cycle. Every fourth word completes a round
// key, which is emitted as a one-cycle RK_VALID pulse with its index.
// DONE coincides with RK12. No backpressure.
//   CLK  clock, rising edge
//   RST  synchronous active-high reset
//   kif  key_expansion_192_if.slave (START/CIPHER_KEY in, round keys out)
// ---------------------------------------------------------------------------
module key_expansion_192 #(
    parameter int NK = 6,
    parameter int NR = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    key_expansion_192_if.slave    kif
);

    import aes192_pkg::*;

    localparam logic [5:0] LAST_WORD  = 6'(4 * NR + 3);
    localparam logic [2:0] PHASE_LAST = 3'(NK - 1);

    state_e state, state_nxt;
    logic   load_en;
    logic   step_en;
    logic   finish_en;

    // win[0] = w[i-6] ... win[5] = w[i-1]
    word_t win [6];
    // first three words of the round key being assembled; the fourth
    // word goes straight from the recurrence into ROUND_KEY
    word_t asm_w [3];

    logic [5:0] word_idx;
    logic [2:0] phase;      // word_idx mod 6
    logic [2:0] rcon_idx;   // 0 selects Rcon[1]

    logic         busy_r;
    logic         rk_valid_r;
    logic         done_r;
    logic [3:0]   rk_index_r;
    logic [127:0] round_key_r;

    word_t rot_word;
    word_t sub_word;
    word_t temp_word;
    word_t w_new;

    assign rot_word = {win[5][23:0], win[5][31:24]};

    sub_word_32 u_sub_word (
        .word_in  (rot_word),
        .word_out (sub_word)
    );

    assign temp_word = (phase == 3'd0) ? (sub_word ^ {RCON[rcon_idx], 24'h0})
                                       : win[5];
    assign w_new     = win[0] ^ temp_word;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        step_en   = 1'b0;
        finish_en = 1'b0;
        case (state)
            IDLE: begin
                if (kif.START) begin
                    load_en   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                step_en   = 1'b1;
                state_nxt = GEN;
            end
            GEN: begin
                // the DONE cycle generates nothing; it only closes the run
                if (done_r) begin
                    finish_en = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    step_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int j = 0; j < 6; j++) win[j] <= '0;
            for (int j = 0; j < 3; j++) asm_w[j] <= '0;
            word_idx    <= '0;
            phase       <= '0;
            rcon_idx    <= '0;
            busy_r      <= 1'b0;
            rk_valid_r  <= 1'b0;
            done_r      <= 1'b0;
            rk_index_r  <= '0;
            round_key_r <= '0;
        end else begin
            rk_valid_r <= 1'b0;
            done_r     <= 1'b0;
            if (load_en) begin
                for (int j = 0; j < 6; j++) win[j] <= kif.CIPHER_KEY[32*j +: 32];
                // RK1 begins with key words 4 and 5
                asm_w[0]    <= kif.CIPHER_KEY[128 +: 32];
                asm_w[1]    <= kif.CIPHER_KEY[160 +: 32];
                asm_w[2]    <= '0;
                word_idx    <= 6'd6;
                phase       <= 3'd0;
                rcon_idx    <= 3'd0;
                busy_r      <= 1'b1;
                rk_valid_r  <= 1'b1;
                rk_index_r  <= 4'd0;
                round_key_r <= kif.CIPHER_KEY[0:127];
            end else if (step_en) begin
                for (int j = 0; j < 5; j++) win[j] <= win[j+1];
                win[5] <= w_new;
                case (word_idx[1:0])
                    2'd0: asm_w[0] <= w_new;
                    2'd1: asm_w[1] <= w_new;
                    2'd2: asm_w[2] <= w_new;
                    default: begin
                        round_key_r <= {asm_w[0], asm_w[1], asm_w[2], w_new};
                        rk_valid_r  <= 1'b1;
                        rk_index_r  <= word_idx[5:2];
                    end
                endcase
                word_idx <= word_idx + 6'd1;
                phase    <= (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;
                if (phase == 3'd0 && rcon_idx != 3'd7) begin
                    rcon_idx <= rcon_idx + 3'd1;
                end
                if (word_idx == LAST_WORD) begin
                    done_r <= 1'b1;
                end
            end
            if (finish_en) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign kif.BUSY      = busy_r;
    assign kif.RK_VALID  = rk_valid_r;
    assign kif.RK_INDEX  = rk_index_r;
    assign kif.ROUND_KEY = round_key_r;
    assign kif.DONE      = done_r;

endmodule

// File: doc/key_expansion_192.md
Name: key_expansion_192

Overview:
Iterative AES-192 key schedule generator: loads a 192-bit cipher key and produces the 13 round keys RK0..RK12, one expanded 32-bit word per cycle. It sits upstream of the input stage and round stages. RK0 feeds the initial AddRoundKey XOR; RK1..RK12 feed the round stages. Round keys are emitted as single-cycle valid pulses with an index, with no backpressure.

Parameters:
NK, 6, key length in 32-bit words; only 6 is supported.
NR, 12, number of rounds; 13 round keys are produced; only 12 is supported.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous, active-high reset.
START  input  1  single-cycle request to expand CIPHER_KEY; honoured only in IDLE.
CIPHER_KEY  input  [0:191]  key; bit 0 is the MSB; word j occupies bits [32j:32j+31]; sampled only in the START cycle.
BUSY  output  1  high from the cycle after an accepted START through the DONE cycle.
RK_VALID  output  1  one-cycle pulse; ROUND_KEY and RK_INDEX are valid in that cycle.
RK_INDEX  output  [0:3]  round key number, 0..12.
ROUND_KEY  output  [0:127]  w[4k]..w[4k+3], with w[4k] in bits [0:31].
DONE  output  1  one-cycle pulse, coincident with RK12.

Behaviour:
- Reset: clock and reset are one clock, synchronous active-high reset (ports CLK, RST). On RST: state=IDLE; BUSY, RK_VALID and DONE are 0; RK_INDEX=0; ROUND_KEY=0; word window and counter cleared.
- RST mid-expansion aborts immediately: no further pulses, back to IDLE.
- States: IDLE -> LOAD (START=1) -> GEN -> IDLE (after the DONE cycle).
- START is ignored while BUSY. START and RST in the same cycle: RST wins.
- Timing, with START accepted in cycle T:
  - T+1 (LOAD): RK_VALID=1, RK_INDEX=0, ROUND_KEY=CIPHER_KEY[0:127]. w6 is computed combinationally and registered at the end of T+1.
  - GEN: w[i] is registered at the end of cycle T+i-5, for i=6..51 (one word per cycle).
  - RK_k for k=1..12: RK_VALID in cycle T+4k-1 (RK1 at T+3, RK12 at T+47).
  - DONE=1 at T+47; IDLE at T+48; a new START is accepted from T+48.
- Word recurrence: w[i] = w[i-6] ^ temp.
  - i mod 6 = 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/6], 24'h0}. Rcon[1..8] = 01,02,04,08,10,20,40,80.
  - Otherwise: temp = w[i-1]. AES-192 has no extra SubWord at i mod 6 = 4.
- Storage: a 6-word sliding window holds w[i-6..i-1]; a 4-word assembly register builds the round key.
- Counters: 6-bit word counter i (6..51); Rcon index increments each time i mod 6 = 0. No counter wraps within one run.
- Outputs are registered. ROUND_KEY and RK_INDEX hold their last emitted values between pulses; RK_VALID is 0 between pulses.

Decomposition:
- Shared package aes192_pkg:
  - constants NK=6, NR=12, NUM_WORDS=52, NUM_RK=13;
  - RCON table (8 bytes);
  - state encoding (IDLE, LOAD, GEN);
  - 32-bit word type.
- Sub-module sub_word_32: four instances of the codebase's byte S-box, combinational, applied to RotWord(w[i-1]).

Test Plan:
- Zero key, START at T -> RK0 = 0 at T+1; RK1 = 00000000 00000000 62636363 62636363 at T+3, RK_INDEX=1.
- FIPS-197 A.2 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - RK1 = 62f8ead2 522c6b7b fe0c91f7 2402f5a5;
  - RK2 starts ec12068e 6c827f6b;
  - RK12 = e98ba06f 448c773c 8ecc7204 01002202 at T+47, with DONE=1.
- Pulse count: exactly 13 RK_VALID pulses per START, indices 0..12 in order, spacing 2 then 4 cycles; BUSY high T+1..T+47.
- START pulsed again at T+10 -> ignored: key is unchanged and the pulse sequence is undisturbed. START at T+48 -> a new run starts cleanly.
- RST asserted at T+20 -> next cycle: BUSY=0, RK_VALID=0, ROUND_KEY=0, DONE never pulses; a subsequent START gives a correct full run.
- Back-to-back: a different key in the second run -> second-run RK0 equals the new key's first 128 bits; no stale words from the first run.
